// File: rtl/fir_coeff_loader.sv
// Byte-stream coefficient loader for the FIR filter: receives checksummed frames,
// stages them in a shadow register and commits them atomically on the sample strobe.
module fir_coeff_loader #(
  parameter int NTAPS   = 7,
  parameter int CW      = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  input  logic                  clk_enable,
  output logic [NTAPS*CW-1:0]   eff,
  output logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BW = NTAPS * CW;
  localparam int NBYTES = BW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST_PAYLOAD = 4'(NBYTES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX = {TW{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t state, state_nxt;

  logic [BW-1:0] shadow;
  logic [7:0]    sum;
  logic [3:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          bypass;

  logic hs;
  logic start_load, start_bypass, take_payload, ck_ok, ck_bad, timeout_hit, commit;

  assign s_ready = (state != PEND);
  assign busy    = (state != IDLE);
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // byte_cnt holds the number of payload bytes already taken, so the byte
  // arriving when it equals the payload length is the checksum.
  always_comb begin
    state_nxt    = state;
    start_load   = 1'b0;
    start_bypass = 1'b0;
    take_payload = 1'b0;
    ck_ok        = 1'b0;
    ck_bad       = 1'b0;
    timeout_hit  = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          if (s_data == 8'hA5) begin
            start_load = 1'b1;
            state_nxt  = LOAD;
          end else if (s_data == 8'h5A) begin
            start_bypass = 1'b1;
            state_nxt    = PEND;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          if (byte_cnt == LAST_PAYLOAD) begin
            if (s_data == sum) begin
              ck_ok     = 1'b1;
              state_nxt = PEND;
            end else begin
              ck_bad    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            take_payload = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      PEND: begin
        if (clk_enable) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow   <= '0;
      sum      <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      bypass   <= 1'b0;
      eff      <= '0;
      en       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= commit;
      err  <= ck_bad || timeout_hit;

      if (start_load) begin
        sum      <= '0;
        byte_cnt <= '0;
        bypass   <= 1'b0;
      end else if (take_payload) begin
        shadow   <= {shadow[BW-9:0], s_data};
        sum      <= sum + s_data;
        byte_cnt <= byte_cnt + 4'd1;
      end else if (ck_bad || timeout_hit) begin
        shadow <= '0;
      end

      if (start_bypass) bypass <= 1'b1;

      // Idle-cycle counter saturates so it can never wrap back below the limit.
      if (start_load || hs)
        to_cnt <= '0;
      else if (state == LOAD && to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;

      if (commit) begin
        if (bypass) begin
          en <= 1'b0;
        end else begin
          eff <= shadow;
          en  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader (TIMEOUT shortened to 20).
module tb_fir_coeff_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic [7:0]   s_data;
  logic         s_ready;
  logic         clk_enable;
  logic [111:0] eff;
  logic         en, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  fir_coeff_loader #(.NTAPS(7), .CW(16), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .clk_enable(clk_enable), .eff(eff), .en(en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Called at a falling edge: drive inputs, let one rising edge consume them,
  // and return at the next falling edge so outputs can be sampled.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ce);
    s_valid = v;
    s_data = d;
    clk_enable = ce;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sendFrame(input logic [111:0] set, input logic [7:0] cks, input logic ce_last);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, set[111-8*i -: 8], 1'b0);
    applyStimulus(1'b1, cks, ce_last);
  endtask

  localparam logic [111:0] UNIT = {7{16'h0100}};
  localparam logic [111:0] BAD  = {16'h4000, {6{16'h0000}}};
  localparam logic [111:0] SET2 = {16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                   16'h0005, 16'h0006, 16'h0007};
  localparam logic [111:0] SET3 = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                   16'h1111, 16'h2222, 16'h3333};
  localparam logic [111:0] SET5 = {16'hFFFF, {6{16'h0000}}};

  initial begin
    logic [111:0] s3;
    logic [7:0]   stream[$];
    logic [111:0] sa, sb;
    int idx, cyc, done_cnt;
    logic rdy, v;

    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; clk_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_eff", eff, '0);
    checkOutput("reset_en", en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", s_ready, 1);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);

    // Reset asserted in the middle of a frame
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("midload_busy", busy, 1);
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", s_ready, 1);
    checkOutput("midrst_eff", eff, '0);
    checkOutput("midrst_en", en, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err, 0);

    // Unit-gain load, strobe several cycles later
    sendFrame(UNIT, 8'h07, 1'b0);
    checkOutput("unit_pend_busy", busy, 1);
    checkOutput("unit_pend_ready", s_ready, 0);
    checkOutput("unit_pend_eff", eff, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("unit_prestrobe_eff", eff, '0);
    checkOutput("unit_prestrobe_done", done, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("unit_eff", eff, UNIT);
    checkOutput("unit_en", en, 1);
    checkOutput("unit_done", done, 1);
    checkOutput("unit_busy", busy, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("unit_done_fall", done, 0);

    // Bad checksum: 0x41 instead of 0x40
    sendFrame(BAD, 8'h41, 1'b0);
    checkOutput("bad_err", err, 1);
    checkOutput("bad_busy", busy, 0);
    checkOutput("bad_done", done, 0);
    checkOutput("bad_eff", eff, UNIT);
    checkOutput("bad_en", en, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bad_err_fall", err, 0);

    // Valid frame after error; strobe on the checksum edge must not commit
    sendFrame(SET2, 8'h1C, 1'b1);
    checkOutput("set2_nocommit_busy", busy, 1);
    checkOutput("set2_nocommit_eff", eff, UNIT);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("pend_ready", s_ready, 0);
    checkOutput("pend_busy", busy, 1);
    applyStimulus(1'b1, 8'h33, 1'b1);
    checkOutput("set2_eff", eff, SET2);
    checkOutput("set2_done", done, 1);
    checkOutput("set2_busy", busy, 0);

    // Stray byte in IDLE is ignored
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("stray_busy", busy, 0);
    checkOutput("stray_err", err, 0);
    checkOutput("stray_done", done, 0);

    // Bypass command
    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkOutput("byp_busy", busy, 1);
    checkOutput("byp_en_hold", en, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("byp_en", en, 0);
    checkOutput("byp_eff", eff, SET2);
    checkOutput("byp_done", done, 1);

    // Timeout: header + 5 payload bytes, then 20 idle edges
    s3 = SET3;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, s3[111-8*i -: 8], 1'b0);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("to19_busy", busy, 1);
    checkOutput("to19_err", err, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("to20_err", err, 1);
    checkOutput("to20_busy", busy, 0);
    checkOutput("to20_eff", eff, SET2);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // 19-cycle stall followed by a byte does not abort
    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, s3[111-8*i -: 8], 1'b0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 5; i < 14; i++) applyStimulus(1'b1, s3[111-8*i -: 8], 1'b0);
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_err", err, 0);
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("stall_pend_ready", s_ready, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stall_eff", eff, SET3);
    checkOutput("stall_en", en, 1);
    checkOutput("stall_done", done, 1);

    // Back-to-back frames, s_valid held, strobe every 4th cycle
    sa = UNIT;
    sb = SET5;
    stream.push_back(8'hA5);
    for (int i = 0; i < 14; i++) stream.push_back(sa[111-8*i -: 8]);
    stream.push_back(8'h07);
    stream.push_back(8'hA5);
    for (int i = 0; i < 14; i++) stream.push_back(sb[111-8*i -: 8]);
    stream.push_back(8'hFE);
    idx = 0; cyc = 0; done_cnt = 0;
    while ((idx < 32 || busy) && cyc < 200) begin
      rdy = s_ready;
      v = (idx < 32);
      applyStimulus(v, v ? stream[idx] : 8'h00, (cyc % 4) == 3);
      if (v && rdy) idx++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) checkOutput("b2b_first_eff", eff, UNIT);
        else               checkOutput("b2b_second_eff", eff, SET5);
      end
      checkOutput("b2b_no_err", err, 0);
      cyc++;
    end
    checkOutput("b2b_in_time", (cyc < 200), 1);
    checkOutput("b2b_done_count", done_cnt, 2);
    checkOutput("b2b_final_eff", eff, SET5);
    checkOutput("b2b_final_en", en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
